// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared state type and device address map for the LC-3 memory controller
package lc3_mem_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
    localparam logic [15:0] DEV_BASE  = 16'hFE00;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;
    localparam logic [15:0] DSR_READY = 16'h8000;
endpackage

// File: rtl/lc3_sram.sv
// lc3_sram: single-port synchronous RAM, write-first, one-cycle read latency
module lc3_sram #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);
    logic [15:0] mem [0:(2**AW)-1];
    // write-first: a written word appears on rdata in the same cycle
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata <= wdata;
        end else
            rdata <= mem[addr];
    end
endmodule

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: answers MIO_EN requests with RAM/device accesses and raises R when done
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int RAM_AW      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_in,
    output logic [15:0] mem_data_out,
    output logic        r_bit,
    output logic        ddr_valid,
    output logic [7:0]  ddr_data,
    input  logic        init_we,
    input  logic [15:0] init_addr,
    input  logic [15:0] init_data
);
    mem_state_t        state;
    logic [3:0]        cnt;
    logic [15:0]       lat_addr, lat_data, dout_q, rdata, dev_data;
    logic              lat_rw, sel_ram, access, ram_hit, ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [15:0]       ram_wdata;

    // the RAM is shared by the preload port (IDLE only) and the latched request
    assign access    = state == BUSY && cnt == 4'd0;
    assign ram_hit   = lat_addr < DEV_BASE && (lat_addr >> RAM_AW) == 16'h0000;
    assign ram_we    = (state == IDLE && init_we) || (access && lat_rw && ram_hit);
    assign ram_addr  = state == IDLE ? init_addr[RAM_AW-1:0] : lat_addr[RAM_AW-1:0];
    assign ram_wdata = state == IDLE ? init_data : lat_data;
    assign dev_data  = lat_addr == DSR_ADDR ? DSR_READY :
                       lat_addr == DDR_ADDR ? {8'h00, ddr_data} : 16'h0000;
    // RAM read data arrives on the access edge itself, so it is muxed out directly
    assign mem_data_out = sel_ram ? rdata : dout_q;

    lc3_sram #(.AW(RAM_AW)) u_sram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (rdata)
    );

    // request sequencing: latch in IDLE, count wait states in BUSY, hold R in DONE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_addr  <= 16'h0000;
            lat_data  <= 16'h0000;
            lat_rw    <= 1'b0;
            r_bit     <= 1'b0;
            sel_ram   <= 1'b0;
            dout_q    <= 16'h0000;
            ddr_valid <= 1'b0;
            ddr_data  <= 8'h00;
        end else begin
            ddr_valid <= 1'b0;
            case (state)
                IDLE: if (mio_en) begin
                    lat_addr <= mar;
                    lat_data <= mdr_in;
                    lat_rw   <= r_w;
                    cnt      <= 4'(WAIT_CYCLES);
                    state    <= BUSY;
                end
                BUSY: if (cnt != 4'd0)
                    cnt <= cnt - 4'd1;
                else begin
                    state   <= DONE;
                    r_bit   <= 1'b1;
                    sel_ram <= !lat_rw && ram_hit;
                    dout_q  <= lat_rw ? lat_data : dev_data;
                    if (lat_rw && lat_addr == DDR_ADDR) begin
                        ddr_valid <= 1'b1;
                        ddr_data  <= lat_data[7:0];
                    end
                end
                DONE: if (!mio_en) begin
                    state   <= IDLE;
                    r_bit   <= 1'b0;
                    sel_ram <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: directed checks of latency, RAM, device registers and reset abort
module tb_lc3_mem_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mio_en = 1'b0;
    logic        r_w = 1'b0;
    logic [15:0] mar = 16'h0000;
    logic [15:0] mdr_in = 16'h0000;
    logic [15:0] mem_data_out;
    logic        r_bit;
    logic        ddr_valid;
    logic [7:0]  ddr_data;
    logic        init_we = 1'b0;
    logic [15:0] init_addr = 16'h0000;
    logic [15:0] init_data = 16'h0000;
    int          checks = 0;
    int          failures = 0;
    int          ddr_pulses = 0;
    logic [7:0]  ddr_seen = 8'h00;

    lc3_mem_ctrl #(.WAIT_CYCLES(2), .RAM_AW(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .mio_en       (mio_en),
        .r_w          (r_w),
        .mar          (mar),
        .mdr_in       (mdr_in),
        .mem_data_out (mem_data_out),
        .r_bit        (r_bit),
        .ddr_valid    (ddr_valid),
        .ddr_data     (ddr_data),
        .init_we      (init_we),
        .init_addr    (init_addr),
        .init_data    (init_data)
    );

    always #5 clk = ~clk;

    // count DDR strobe cycles and remember the character they carried
    always @(negedge clk) begin
        if (ddr_valid) begin
            ddr_pulses++;
            ddr_seen = ddr_data;
        end
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        init_we = 1'b1;
        init_addr = a;
        init_data = d;
        @(negedge clk);
        init_we = 1'b0;
    endtask

    // issue a request at a negedge; r_bit must be seen at the 4th following negedge (edge k+3)
    task automatic access(input string tag, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic [15:0] exp, input logic drop_early);
        int n;
        n = 0;
        mio_en = 1'b1;
        r_w = w;
        mar = a;
        mdr_in = d;
        do begin
            @(negedge clk);
            n++;
            if (drop_early) mio_en = 1'b0;
        end while (!r_bit && n < 20);
        chk({tag, "_latency"}, 16'(n), 16'd4);
        chk({tag, "_rbit"}, {15'd0, r_bit}, 16'd1);
        chk({tag, "_data"}, mem_data_out, exp);
        mio_en = 1'b0;
        @(negedge clk);
        chk({tag, "_rfall"}, {15'd0, r_bit}, 16'd0);
    endtask

    initial begin
        mio_en = 1'b1;
        mar = 16'hFE04;
        @(negedge clk);
        @(negedge clk);
        chk("rst_rbit", {15'd0, r_bit}, 16'd0);
        chk("rst_data", mem_data_out, 16'h0000);
        chk("rst_ddrv", {15'd0, ddr_valid}, 16'd0);
        chk("rst_ddrd", {8'd0, ddr_data}, 16'h0000);
        reset = 1'b0;
        access("dsr_first", 1'b0, 16'hFE04, 16'h0000, 16'h8000, 1'b0);

        preload(16'h3000, 16'h1234);
        access("rd3000", 1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b0);

        access("wr3001", 1'b1, 16'h3001, 16'hBEEF, 16'hBEEF, 1'b0);
        access("rd3001", 1'b0, 16'h3001, 16'h0000, 16'hBEEF, 1'b0);
        chk("no_ddr_strobe", 16'(ddr_pulses), 16'd0);

        access("wr_ddr", 1'b1, 16'hFE06, 16'h0041, 16'h0041, 1'b0);
        chk("ddr_pulse_cnt", 16'(ddr_pulses), 16'd1);
        chk("ddr_char", {8'd0, ddr_seen}, 16'h0041);
        access("wr_dsr", 1'b1, 16'hFE04, 16'h1111, 16'h1111, 1'b0);
        access("rd_dsr", 1'b0, 16'hFE04, 16'h0000, 16'h8000, 1'b0);
        access("rd_ddr", 1'b0, 16'hFE06, 16'h0000, 16'h0041, 1'b0);
        chk("ddr_pulse_cnt2", 16'(ddr_pulses), 16'd1);

        access("rd_unmapped", 1'b0, 16'hFE10, 16'h0000, 16'h0000, 1'b0);
        access("wr_unmapped", 1'b1, 16'hFE10, 16'h5555, 16'h5555, 1'b0);
        access("drop_busy", 1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b1);

        preload(16'h3002, 16'h0007);
        mio_en = 1'b1;
        r_w = 1'b1;
        mar = 16'h3002;
        mdr_in = 16'h9999;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_rbit", {15'd0, r_bit}, 16'd0);
        chk("abort_data", mem_data_out, 16'h0000);
        mio_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_idle_rbit", {15'd0, r_bit}, 16'd0);
        access("rd3002", 1'b0, 16'h3002, 16'h0000, 16'h0007, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
